// File: rtl/adder_tree_pkg.sv
// Shared types and elaboration-time helpers for the pipelined multi-operand adder tree.
// Tree geometry is derived from the operand count, so every file sizes itself the same way.
package adder_tree_pkg;

  // Sideband carried alongside the data through every pipeline stage.
  typedef struct packed {
    logic valid;
    logic acc;
    logic clr;
  } sb_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) begin
      r++;
    end
    return r;
  endfunction

  // Number of registered reduction levels: the operands plus the carry-in leaf.
  function automatic int levels(input int num_ops);
    return clog2(num_ops + 1);
  endfunction

  function automatic int sum_w(input int width, input int num_ops);
    return width + levels(num_ops);
  endfunction

  // Entries present after k pairing levels, starting from n leaves.
  function automatic int level_n(input int n, input int k);
    int r;
    r = n;
    for (int i = 0; i < k; i++) begin
      r = (r + 1) / 2;
    end
    return r;
  endfunction

  // Offset of level k inside a flat array that stores all levels back to back.
  function automatic int node_off(input int n, input int k);
    int r;
    r = 0;
    for (int i = 0; i < k; i++) begin
      r += level_n(n, i);
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_pipe_if.sv
// Operand/result bus of the adder tree: valid/ready on the operand side and on the result side.
// The master is the producer/consumer environment, the slave is the adder tree.
interface adder_tree_pipe_if #(
  parameter int WIDTH   = 7,
  parameter int NUM_OPS = 10,
  parameter int ACC_W   = 16
);
  import adder_tree_pkg::*;

  localparam int SUM_W = sum_w(WIDTH, NUM_OPS);

  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_OPS*WIDTH-1:0]   ops;
  logic                       ci;
  logic                       in_acc;
  logic                       in_clr;
  logic                       out_valid;
  logic                       out_ready;
  logic [SUM_W-1:0]           sum;
  logic [WIDTH-1:0]           s;
  logic                       co;
  logic [ACC_W-1:0]           acc;
  logic                       acc_ovf;

  modport master (
    output in_valid, ops, ci, in_acc, in_clr, out_ready,
    input  in_ready, out_valid, sum, s, co, acc, acc_ovf
  );

  modport slave (
    input  in_valid, ops, ci, in_acc, in_clr, out_ready,
    output in_ready, out_valid, sum, s, co, acc, acc_ovf
  );

endinterface

// File: rtl/adder_tree_level.sv
// One registered reduction level: adjacent entries are added pairwise, an odd tail passes through.
// Data and sideband load together whenever the pipeline is not stalled, bubbles included.
module adder_tree_level
  import adder_tree_pkg::*;
#(
  parameter int IN_N  = 11,
  parameter int SUM_W = 11
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              en,
  input  logic [IN_N-1:0][SUM_W-1:0]        in_data,
  input  sb_t                               in_sb,
  output logic [(IN_N+1)/2-1:0][SUM_W-1:0]  out_data,
  output sb_t                               out_sb
);

  localparam int OUT_N = (IN_N + 1) / 2;

  logic [OUT_N-1:0][SUM_W-1:0] data_next;

  genvar gi;
  generate
    for (gi = 0; gi < OUT_N; gi++) begin : g_pair
      if (2 * gi + 1 < IN_N) begin : g_add
        assign data_next[gi] = in_data[2*gi] + in_data[2*gi+1];
      end else begin : g_pass
        assign data_next[gi] = in_data[2*gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      out_sb   <= '0;
    end else if (en) begin
      out_data <= data_next;
      out_sb   <= in_sb;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Pipelined NUM_OPS-operand adder tree with carry-in, valid/ready flow control and an
// optional running accumulator folded into the final reduction stage.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int WIDTH   = 7,
  parameter int NUM_OPS = 10,
  parameter int ACC_W   = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  adder_tree_pipe_if.slave bus
);

  localparam int LEVELS = levels(NUM_OPS);
  localparam int SUM_W  = sum_w(WIDTH, NUM_OPS);
  localparam int N0     = NUM_OPS + 1;
  localparam int LAST   = node_off(N0, LEVELS - 1);
  localparam int TOT    = LAST + 2;
  localparam int ACC_W1 = ACC_W + 1;

  // Every level's entries live in one flat array; level k starts at node_off(N0, k).
  logic [TOT-1:0][SUM_W-1:0] nodes;
  sb_t  [LEVELS-1:0]         sbs;

  logic             stall;
  logic             en;
  logic [SUM_W-1:0] sum_next;
  logic [ACC_W:0]   acc_add;
  logic             acc_beat;
  sb_t              last_sb;

  logic             out_valid_reg;
  logic [SUM_W-1:0] sum_reg;
  logic [ACC_W-1:0] acc_reg;
  logic [ACC_W-1:0] acc_out_reg;
  logic             acc_ovf_reg;

  // A held result freezes the whole pipe, bubbles included, so nothing is dropped or duplicated.
  assign stall        = out_valid_reg && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = !stall;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OPS; gi++) begin : g_leaf
      assign nodes[gi] = SUM_W'(bus.ops[gi*WIDTH +: WIDTH]);
    end
  endgenerate

  assign nodes[NUM_OPS] = SUM_W'(bus.ci);
  assign sbs[0]         = '{valid: bus.in_valid, acc: bus.in_acc, clr: bus.in_clr};

  generate
    for (gi = 0; gi < LEVELS - 1; gi++) begin : g_lvl
      localparam int IN_N  = level_n(N0, gi);
      localparam int OUT_N = level_n(N0, gi + 1);
      localparam int I_OFF = node_off(N0, gi);
      localparam int O_OFF = node_off(N0, gi + 1);

      adder_tree_level #(
        .IN_N  (IN_N),
        .SUM_W (SUM_W)
      ) u_level (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .in_data  (nodes[I_OFF +: IN_N]),
        .in_sb    (sbs[gi]),
        .out_data (nodes[O_OFF +: OUT_N]),
        .out_sb   (sbs[gi+1])
      );
    end
  endgenerate

  // Final level: the last pair is reduced and the accumulator updated on the same edge.
  assign last_sb  = sbs[LEVELS-1];
  assign sum_next = nodes[LAST] + nodes[LAST+1];
  assign acc_beat = last_sb.valid && last_sb.acc;
  assign acc_add  = {1'b0, acc_reg} + ACC_W1'(sum_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      sum_reg       <= '0;
      acc_reg       <= '0;
      acc_out_reg   <= '0;
      acc_ovf_reg   <= 1'b0;
    end else if (en) begin
      out_valid_reg <= last_sb.valid;
      sum_reg       <= sum_next;
      if (acc_beat && last_sb.clr) begin
        acc_reg     <= ACC_W'(sum_next);
        acc_out_reg <= ACC_W'(sum_next);
        acc_ovf_reg <= 1'b0;
      end else if (acc_beat) begin
        acc_reg     <= acc_add[ACC_W-1:0];
        acc_out_reg <= acc_add[ACC_W-1:0];
        acc_ovf_reg <= acc_ovf_reg | acc_add[ACC_W];
      end else begin
        acc_out_reg <= ACC_W'(sum_next);
      end
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.sum       = sum_reg;
  assign bus.s         = sum_reg[WIDTH-1:0];
  assign bus.co        = sum_reg[WIDTH];
  assign bus.acc       = acc_out_reg;
  assign bus.acc_ovf   = acc_ovf_reg;

endmodule

// File: tb/tb_adder_tree_pipe.sv
// Self-checking bench for adder_tree_pipe: directed and random beats on a 16-bit and an
// 11-bit accumulator instance, compared against an arithmetic reference model.
module tb_adder_tree_pipe;

  localparam int WIDTH   = 7;
  localparam int NUM_OPS = 10;
  localparam int LEVELS  = 4;
  localparam int SUM_W   = 11;
  localparam int ACC_A   = 16;
  localparam int ACC_B   = 11;

  typedef struct {
    int unsigned sum;
    int unsigned acc;
    bit          ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  adder_tree_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_W(ACC_A)) bus_a ();
  adder_tree_pipe_if #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_W(ACC_B)) bus_b ();

  adder_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_W(ACC_A)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  adder_tree_pipe #(.WIDTH(WIDTH), .NUM_OPS(NUM_OPS), .ACC_W(ACC_B)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int unsigned op_v [NUM_OPS];
  res_t        q_a [$];
  res_t        q_b [$];
  longint unsigned macc [2];
  bit          movf [2];
  bit          vline [$];
  bit          lat_chk = 1'b0;
  bit          stalled_prev [2];
  logic [63:0] held_sum, held_acc, held_ovf;
  int unsigned pat [NUM_OPS] = '{10, 15, 15, 15, 7, 12, 13, 15, 15, 10};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_OPS*WIDTH-1:0] pack_ops();
    logic [NUM_OPS*WIDTH-1:0] p;
    p = '0;
    for (int k = 0; k < NUM_OPS; k++) p[k*WIDTH +: WIDTH] = 7'(op_v[k]);
    return p;
  endfunction

  task automatic set_all(input int unsigned val);
    for (int k = 0; k < NUM_OPS; k++) op_v[k] = val;
  endtask

  task automatic set_rand();
    for (int k = 0; k < NUM_OPS; k++) op_v[k] = $urandom_range(0, 127);
  endtask

  // Reference: plain sum of all operands plus ci, accumulator kept modulo 2^ACC_W.
  task automatic model(input int sel, input bit ci_b, input bit acc_b, input bit clr_b,
                       output res_t r);
    longint unsigned t, m, x;
    t = 64'(ci_b);
    for (int k = 0; k < NUM_OPS; k++) t += 64'(op_v[k]);
    m = (sel == 0) ? (64'd1 << ACC_A) : (64'd1 << ACC_B);
    if (acc_b && clr_b) begin
      macc[sel] = t;
      movf[sel] = 1'b0;
    end else if (acc_b) begin
      x = macc[sel] + t;
      if (x >= m) begin
        movf[sel] = 1'b1;
        x = x - m;
      end
      macc[sel] = x;
    end
    r.sum = 32'(t);
    r.acc = acc_b ? 32'(macc[sel]) : 32'(t);
    r.ovf = movf[sel];
  endtask

  task automatic drive(input int sel, input bit v, input bit ci_b, input bit acc_b,
                       input bit clr_b, input bit ordy);
    bus_a.in_valid  = (sel == 0) && v;
    bus_a.ops       = pack_ops();
    bus_a.ci        = ci_b;
    bus_a.in_acc    = acc_b;
    bus_a.in_clr    = clr_b;
    bus_a.out_ready = (sel == 0) ? ordy : 1'b1;
    bus_b.in_valid  = (sel == 1) && v;
    bus_b.ops       = pack_ops();
    bus_b.ci        = ci_b;
    bus_b.in_acc    = acc_b;
    bus_b.in_clr    = clr_b;
    bus_b.out_ready = (sel == 1) ? ordy : 1'b1;
  endtask

  // One clock: drive, check the visible result at the falling edge, log acceptance, advance.
  task automatic step(input int sel, input bit v, input bit ci_b, input bit acc_b,
                      input bit clr_b, input bit ordy);
    logic ov, rdy, co_o, ovf_o;
    logic [SUM_W-1:0] sum_o;
    logic [6:0] s_o;
    logic [15:0] acc_o;
    res_t e;
    bit exp_v, accepted;
    int qn;
    drive(sel, v, ci_b, acc_b, clr_b, ordy);
    @(negedge clk);
    if (sel == 0) begin
      ov = bus_a.out_valid; rdy = bus_a.in_ready; sum_o = bus_a.sum; s_o = bus_a.s;
      co_o = bus_a.co; acc_o = bus_a.acc; ovf_o = bus_a.acc_ovf; qn = q_a.size();
    end else begin
      ov = bus_b.out_valid; rdy = bus_b.in_ready; sum_o = bus_b.sum; s_o = bus_b.s;
      co_o = bus_b.co; acc_o = 16'(bus_b.acc); ovf_o = bus_b.acc_ovf; qn = q_b.size();
    end
    check("in_ready_rule", 64'(rdy), 64'(!(ov && !ordy)));
    if (stalled_prev[sel]) begin
      check("hold_sum", 64'(sum_o), held_sum);
      check("hold_acc", 64'(acc_o), held_acc);
      check("hold_ovf", 64'(ovf_o), held_ovf);
    end
    if (lat_chk) begin
      exp_v = vline.pop_front();
      check("latency_valid", 64'(ov), 64'(exp_v));
    end
    if (ov) begin
      if (qn == 0) begin
        check("spurious_valid", 64'(ov), 64'd0);
      end else begin
        e = (sel == 0) ? q_a[0] : q_b[0];
        check("sum", 64'(sum_o), 64'(e.sum));
        check("s", 64'(s_o), 64'(e.sum % 128));
        check("co", 64'(co_o), 64'((e.sum >> 7) & 1));
        check("acc", 64'(acc_o), 64'(e.acc));
        check("acc_ovf", 64'(ovf_o), 64'(e.ovf));
        if (ordy) begin
          if (sel == 0) void'(q_a.pop_front());
          else void'(q_b.pop_front());
        end
      end
    end
    stalled_prev[0] = 1'b0;
    stalled_prev[1] = 1'b0;
    stalled_prev[sel] = ov && !ordy;
    held_sum = 64'(sum_o);
    held_acc = 64'(acc_o);
    held_ovf = 64'(ovf_o);
    accepted = v && rdy;
    if (accepted) begin
      model(sel, ci_b, acc_b, clr_b, e);
      if (sel == 0) q_a.push_back(e);
      else q_b.push_back(e);
    end
    if (lat_chk) vline.push_back(accepted);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 64'(bus_a.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus_a.out_valid), 64'd0);
    check("rst_sum", 64'(bus_a.sum), 64'd0);
    check("rst_s", 64'(bus_a.s), 64'd0);
    check("rst_co", 64'(bus_a.co), 64'd0);
    check("rst_acc", 64'(bus_a.acc), 64'd0);
    check("rst_acc_ovf", 64'(bus_a.acc_ovf), 64'd0);
    check("rst_b_out_valid", 64'(bus_b.out_valid), 64'd0);
    check("rst_b_acc", 64'(bus_b.acc), 64'd0);
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    vline.delete();
    macc[0] = 0; macc[1] = 0;
    movf[0] = 1'b0; movf[1] = 1'b0;
    stalled_prev[0] = 1'b0; stalled_prev[1] = 1'b0;
  endtask

  initial begin
    clear_model();
    set_all(0);
    drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Latency and back-to-back beats with the consumer always ready.
    lat_chk = 1'b1;
    for (int i = 0; i < LEVELS; i++) vline.push_back(1'b0);
    set_all(1);  step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_all(0);
    repeat (5) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NUM_OPS; k++) op_v[k] = k + 1;
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_all(12); step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    set_all(0);  step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < NUM_OPS; k++) op_v[k] = pat[k];
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    set_all(127); step(0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    set_all(0);
    repeat (6) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Accumulate chain with an interleaved plain beat.
    set_all(1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    lat_chk = 1'b0;
    vline.delete();

    // Backpressure: consumer stalls while the producer keeps offering beats.
    for (int i = 0; i < 6; i++) begin
      set_rand(); step(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      set_rand(); step(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
    end
    check("bp_out_valid", 64'(bus_a.out_valid), 64'd1);
    check("bp_in_ready", 64'(bus_a.in_ready), 64'd0);
    repeat (8) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("bp_drained", 64'(q_a.size()), 64'd0);

    // 11-bit accumulator: wrap, sticky overflow, ignored clr, then clear.
    set_all(127);
    step(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    set_all(0);  step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    set_all(1);  step(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (6) step(1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_drained", 64'(q_b.size()), 64'd0);

    // Random traffic with random stalls and accumulate controls.
    for (int i = 0; i < 80; i++) begin
      set_rand();
      step(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0);
    end
    repeat (8) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("rand_drained", 64'(q_a.size()), 64'd0);

    // Reset with a result showing and three beats still in the tree.
    set_all(1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    repeat (3) step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    bus_a.in_valid = 1'b0;
    bus_a.out_ready = 1'b0;
    #2;
    check("pre_rst_in_ready", 64'(bus_a.in_ready), 64'd0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs();
    clear_model();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_all(0);
    repeat (8) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    set_all(1);
    step(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (6) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("final_drained", 64'(q_a.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
